// File: rtl/shared_divider_pkg.sv
// Shared bike-computer divider definitions: FSM encoding and default sizing
// used by the speed and average-speed blocks.
package shared_divider_pkg;

    localparam int DIV_WIDTH = 16;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/shared_divider_step.sv
// One unsigned restoring radix-2 division step. The dividend register doubles
// as the quotient register: each step shifts out a dividend bit and shifts in a quotient bit.
module div_step
    import shared_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic             unused_trial_bit;

    // Two guard bits so the sign of the trial subtraction is never aliased
    assign shifted          = {rem, dvd[WIDTH-1]};
    assign trial            = {1'b0, shifted} - {2'b00, dsr};
    assign fits             = ~trial[WIDTH+1];
    assign unused_trial_bit = trial[WIDTH];

    assign rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign dvd_next = {dvd[WIDTH-2:0], fits};

endmodule

// File: rtl/shared_divider.sv
// Iterative divider time-shared between two clients with round-robin
// arbitration; one restoring step per cycle, result held until the owner drops start.
module shared_divider
    import shared_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start0,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic             start1,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dz,
    output logic             busy,
    output logic             ready,
    output logic             gnt
);

    div_state_t       state;
    div_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             req_any;
    logic             grant_idx;
    logic             owner_start;
    logic             last_step;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] dvd_acc;
    logic [WIDTH-1:0] dsr_reg;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;

    // Pointer only matters when both clients request at once
    assign req_any     = start0 | start1;
    assign grant_idx   = (start0 & start1) ? ptr : start1;
    assign owner_start = gnt ? start1 : start0;
    assign last_step   = (cnt == CNT_W'(1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_acc),
        .dvd      (dvd_acc),
        .dsr      (dsr_reg),
        .rem_next (rem_step),
        .dvd_next (dvd_step)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any)      state_next = CALC;
            CALC:    if (last_step)    state_next = DONE;
            DONE:    if (!owner_start) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == CALC);
        ready = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            ptr       <= 1'b0;
            gnt       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt <= grant_idx;
                        ptr <= ~grant_idx;
                        cnt <= CNT_W'(WIDTH);
                    end
                end
                CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        quotient  <= dvd_step;
                        remainder <= rem_step;
                        dz        <= (dsr_reg == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Working registers are don't-care outside CALC, so they carry no reset
    always_ff @(posedge clk) begin
        if (state == IDLE && req_any) begin
            rem_acc <= '0;
            dvd_acc <= grant_idx ? dividend1 : dividend0;
            dsr_reg <= grant_idx ? divisor1  : divisor0;
        end else if (state == CALC) begin
            rem_acc <= rem_step;
            dvd_acc <= dvd_step;
        end
    end

endmodule

// File: tb/tb_shared_divider.sv
// Scoreboard bench for shared_divider: stimulus pushes expected results from
// plain-arithmetic division, a negedge monitor pops and compares on each ready.
module tb_shared_divider;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start0 = 1'b0, start1 = 1'b0;
    logic [W-1:0]  dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
    logic [W-1:0]  quotient, remainder;
    logic          dz, busy, ready, gnt;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         g;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   errors = 0;
    int   checks = 0;
    bit   ptr_m  = 1'b0;
    logic ready_d = 1'b0;

    shared_divider #(.WIDTH(W), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .start0    (start0),
        .dividend0 (dividend0),
        .divisor0  (divisor0),
        .start1    (start1),
        .dividend1 (dividend1),
        .divisor1  (divisor1),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz),
        .busy      (busy),
        .ready     (ready),
        .gnt       (gnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic g);
        exp_t e;
        if (b == 0) begin
            e.q = '1;  e.r = a;  e.dz = 1'b1;
        end else begin
            e.q = a / b;  e.r = a % b;  e.dz = 1'b0;
        end
        e.g = g;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Monitor: compare on each rising ready, then demand stability while it stays high
    always @(negedge clk) begin
        check("busy_ready_exclusive", {31'd0, busy & ready}, 32'd0);
        if (ready && !ready_d) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1, want no pending result at %0t", $time);
            end else begin
                cur = sb.pop_front();
                check("quotient",  quotient,  cur.q);
                check("remainder", remainder, cur.r);
                check("dz",        dz,        cur.dz);
                check("gnt",       gnt,       cur.g);
            end
        end else if (ready) begin
            check("quotient_stable",  quotient,  cur.q);
            check("remainder_stable", remainder, cur.r);
            check("dz_stable",        dz,        cur.dz);
        end
        ready_d <= ready;
    end

    // Waits for ready; scrambles the running client's operands mid-calculation
    task automatic wait_ready(output int lat, input bit chk_busy, input bit client);
        lat = 0;
        while (!ready && lat < 200) begin
            @(negedge clk);
            lat++;
            if (chk_busy && lat == 1) check("busy_after_load", busy, 1);
            if (lat == 5) begin
                if (client) begin dividend1 = $urandom; divisor1 = $urandom; end
                else        begin dividend0 = $urandom; divisor0 = $urandom; end
            end
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0, want ready=1 at %0t", $time);
        end
    endtask

    task automatic finish_client(input bit client, input int hold);
        repeat (hold) @(negedge clk);
        if (client) start1 = 1'b0; else start0 = 1'b0;
        @(negedge clk);
        check("idle_after_drop", {busy, ready}, 2'b00);
    endtask

    task automatic transact(input bit r0, input bit r1,
                            input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [W-1:0] a1, input logic [W-1:0] b1,
                            input int hold, input bit rel_rst);
        bit first;
        int lat;
        @(negedge clk);
        dividend0 = a0; divisor0 = b0; dividend1 = a1; divisor1 = b1;
        start0 = r0; start1 = r1;
        if (rel_rst) rst = 1'b0;
        first = (r0 && r1) ? ptr_m : r1;
        sb.push_back(model(first ? a1 : a0, first ? b1 : b0, first));
        ptr_m = ~first;
        if (r0 && r1) begin
            sb.push_back(model(first ? a0 : a1, first ? b0 : b1, ~first));
            ptr_m = first;
        end
        wait_ready(lat, 1'b1, first);
        check("latency", lat, W + 1);
        finish_client(first, hold);
        if (r0 && r1) begin
            wait_ready(lat, 1'b0, ~first);
            finish_client(~first, hold);
        end
    endtask

    initial begin
        logic [W-1:0] ra0, rb0, ra1, rb1;
        logic [1:0]   k;
        int           lat;

        repeat (3) @(negedge clk);
        check("rst_quotient",  quotient,  0);
        check("rst_remainder", remainder, 0);
        check("rst_dz",        dz,        0);
        check("rst_busy",      busy,      0);
        check("rst_ready",     ready,     0);
        check("rst_gnt",       gnt,       0);

        // Joint request at reset release, then a second joint request
        transact(1, 1, 16'd18875, 16'd5, 16'd300, 16'd20, 0, 1);
        transact(1, 1, 16'd4321, 16'd10, 16'd999, 16'd3, 1, 0);
        transact(1, 0, 16'd1000, 16'd7, 16'd0, 16'd0, 0, 0);
        transact(0, 1, 16'd0, 16'd0, 16'hFFFF, 16'd1, 0, 0);
        transact(0, 1, 16'd0, 16'd0, 16'd5, 16'd0, 2, 0);
        transact(1, 0, 16'd50000, 16'd123, 16'd0, 16'd0, 5, 0);

        for (int i = 0; i < 20; i++) begin
            k   = 2'($urandom_range(1, 3));
            ra0 = $urandom; ra1 = $urandom;
            rb0 = ($urandom_range(0, 4) == 0) ? 16'd0 : (($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom));
            rb1 = ($urandom_range(0, 4) == 0) ? 16'd0 : (($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom));
            transact(k[0], k[1], ra0, rb0, ra1, rb1, $urandom_range(0, 3), 0);
        end

        // Reset in the 8th CALC cycle with start0 still requesting
        @(negedge clk);
        dividend0 = 16'd60000; divisor0 = 16'd7; start0 = 1'b1;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy",      busy,      0);
        check("abort_ready",     ready,     0);
        check("abort_quotient",  quotient,  0);
        check("abort_remainder", remainder, 0);
        check("abort_dz",        dz,        0);
        check("abort_gnt",       gnt,       0);
        rst = 1'b0;
        ptr_m = 1'b0;
        sb.push_back(model(16'd60000, 16'd7, 1'b0));
        ptr_m = 1'b1;
        wait_ready(lat, 1'b1, 1'b0);
        check("latency_after_rst", lat, W + 1);
        finish_client(1'b0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
